// File: rtl/parking_pkg.sv
// Shared definitions for the parking-meter emulator and its receiver:
// FSM state encoding, default bounce length and JB bit positions.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ARR   = 3'd1,
    ST_BOUNCE_IN  = 3'd2,
    ST_PARKED     = 3'd3,
    ST_BOUNCE_OUT = 3'd4,
    ST_FINISH     = 3'd5
  } emu_state_e;

  localparam int BOUNCE_TICKS_DEFAULT = 4;
  localparam int JB_W                 = 8;
  localparam int OCC_BIT              = 0;
  localparam int BUSY_BIT             = 1;

endpackage

// File: rtl/sensor_emulator_tick_counter.sv
// W-bit tick counter with synchronous clear and an equality hit flag.
// Clear wins over increment so the count never runs past the compare value.
module tick_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] cmp,
  output logic         hit
);

  logic [W-1:0] count_r;

  // Count tick strobes, cleared by reset or by the owning FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == cmp);

endmodule

// File: rtl/sensor_emulator.sv
// Scripted arrive/dwell/depart occupancy waveform on JB, timed in tick units,
// with optional contact bounce on both edges.
module sensor_emulator
  import parking_pkg::*;
#(
  parameter int W            = 16,
  parameter int BOUNCE_TICKS = BOUNCE_TICKS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            start,
  input  logic            abort,
  input  logic [W-1:0]    arrive_delay,
  input  logic [W-1:0]    dwell,
  input  logic            bounce_en,
  output logic [JB_W-1:0] JB,
  output logic            busy,
  output logic            done
);

  emu_state_e      state_r;
  logic [W-1:0]    delay_r;
  logic [W-1:0]    dwell_r;
  logic            bounce_r;
  logic            occ_r;
  logic            busy_r;
  logic            done_r;
  logic            clr_s;
  logic            hit_s;
  logic [W-1:0]    cmp_s;
  logic [JB_W-1:0] jb_s;

  // Select what the shared counter is compared against in each phase.
  always_comb begin
    cmp_s = '0;
    case (state_r)
      ST_WAIT_ARR:                 cmp_s = delay_r;
      ST_PARKED:                   cmp_s = dwell_r;
      ST_BOUNCE_IN, ST_BOUNCE_OUT: cmp_s = W'(BOUNCE_TICKS);
      default:                     cmp_s = '0;
    endcase
  end

  // Hold the counter at zero outside timed phases and restart it on every phase change.
  always_comb begin
    clr_s = 1'b0;
    if (abort || hit_s || (state_r == ST_IDLE) || (state_r == ST_FINISH)) begin
      clr_s = 1'b1;
    end else begin
      clr_s = 1'b0;
    end
  end

  tick_counter #(.W(W)) u_tick_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr_s),
    .inc (tick),
    .cmp (cmp_s),
    .hit (hit_s)
  );

  // Sequence FSM with operand latches and registered occupancy/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      delay_r  <= '0;
      dwell_r  <= '0;
      bounce_r <= 1'b0;
      occ_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (abort) begin
      state_r <= ST_IDLE;
      occ_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          occ_r <= 1'b0;
          if (start) begin
            delay_r  <= arrive_delay;
            dwell_r  <= dwell;
            bounce_r <= bounce_en;
            busy_r   <= 1'b1;
            state_r  <= ST_WAIT_ARR;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT_ARR: begin
          if (hit_s) begin
            occ_r   <= 1'b1;
            state_r <= bounce_r ? ST_BOUNCE_IN : ST_PARKED;
          end else begin
            occ_r <= 1'b0;
          end
        end
        ST_BOUNCE_IN: begin
          // The settle edge forces the final level regardless of toggle parity.
          if (hit_s) begin
            occ_r   <= 1'b1;
            state_r <= ST_PARKED;
          end else if (tick) begin
            occ_r <= ~occ_r;
          end else begin
            occ_r <= occ_r;
          end
        end
        ST_PARKED: begin
          if (hit_s) begin
            occ_r   <= 1'b0;
            state_r <= bounce_r ? ST_BOUNCE_OUT : ST_FINISH;
          end else begin
            occ_r <= 1'b1;
          end
        end
        ST_BOUNCE_OUT: begin
          if (hit_s) begin
            occ_r   <= 1'b0;
            state_r <= ST_FINISH;
          end else if (tick) begin
            occ_r <= ~occ_r;
          end else begin
            occ_r <= occ_r;
          end
        end
        ST_FINISH: begin
          occ_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          occ_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Assemble the Pmod byte; unused pins stay low.
  always_comb begin
    jb_s           = '0;
    jb_s[OCC_BIT]  = occ_r;
    jb_s[BUSY_BIT] = busy_r;
  end

  assign JB   = jb_s;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: doc/sensor_emulator.md
# sensor_emulator

Drives a scripted vehicle arrival, dwell and departure onto Pmod header JB so it can be looped back into the occupancy input on JA. Lets the parking-meter datapath be exercised on the board without a physical sensor. Timing is in units of an external `tick` strobe. Optional contact bounce is injected on each edge.

## Interface
Parameters:
- `W`, 16: width of the delay and dwell operands and of the internal tick counter.
- `BOUNCE_TICKS`, 4: number of ticks the bounce phase lasts on each edge; must be ≥1.

Ports:
- `clk`  in  1  board clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  one-`clk`-wide timebase strobe, e.g. 1 kHz.
- `start`  in  1  single-cycle request to run one arrive/dwell/depart sequence.
- `abort`  in  1  synchronous cancel; returns the block to idle.
- `arrive_delay`  in  W  ticks from start to the arrival edge.
- `dwell`  in  W  ticks the vehicle stays parked after the arrival bounce.
- `bounce_en`  in  1  1 = inject bounce on both edges.
- `JB`  out  8  `JB[0]` is the emulated occupancy level, `JB[1]` mirrors `busy`, and `JB[7:2]` is always 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes normally.

## Operation
- FSM states: IDLE, WAIT_ARR, BOUNCE_IN, PARKED, BOUNCE_OUT, FINISH.
- IDLE:
  - `JB[0]`=0.
  - On `start`=1, latch `arrive_delay`, `dwell` and `bounce_en`, clear the counter and go to WAIT_ARR.
- WAIT_ARR:
  - `JB[0]`=0.
  - The counter increments on each `tick`.
  - When counter==latched delay, clear the counter and go to BOUNCE_IN if bounce is latched, else PARKED.
  - A delay of 0 leaves this state on the next `clk`.
- BOUNCE_IN:
  - `JB[0]` is 1 on entry and inverts on each `tick`.
  - After `BOUNCE_TICKS` ticks, go to PARKED and force `JB[0]`=1.
- PARKED:
  - `JB[0]`=1; count ticks to the latched dwell, then clear the counter.
  - Go to BOUNCE_OUT if bounce is latched, else FINISH.
  - A dwell of 0 leaves on the next `clk`.
- BOUNCE_OUT:
  - `JB[0]` is 0 on entry and inverts on each `tick`.
  - After `BOUNCE_TICKS` ticks, go to FINISH and force `JB[0]`=0.
- FINISH: `JB[0]`=0 and `done`=1 for exactly one cycle, then IDLE.
- `abort`=1 in any state:
  - Next state is IDLE, `JB[0]`=0 and the counter is cleared.
  - No `done` pulse is produced.
- Operand latching: operands are captured only at an accepted start; changes while busy have no effect.
- Width: the counter is W bits. Compares are exact equality against the latched operand; the counter never wraps because it stops at the operand value.

## Timing
- All outputs are registered.
- Reset values: `JB`=8'h00, `busy`=0, `done`=0, state IDLE, counter 0.
- `rst` mid-sequence gives the same result as `abort`, and `rst` has priority over `abort`.
- `start` accepted at edge N gives `busy`=1 after edge N.
- Arrival with no bounce:
  - `JB[0]` rises on the `clk` after the tick on which the counter reaches `arrive_delay`.
  - Delay from start is `arrive_delay` ticks plus 1 `clk`.
- `done` rises on the `clk` after `JB[0]` returns to its final 0.
- Priority within one cycle: `rst` > `abort` > `start`.
- `start` while `busy`=1 is ignored, as is `start` in FINISH.
- A `tick` coincident with an accepted `start` is not counted.
- A `tick` coincident with a state transition is not counted in the new state.
- `JB[1]` equals `busy` on every cycle.

## Structure
- Shared package `parking_pkg` holds:
  - state enum/localparams for the FSM;
  - the default `BOUNCE_TICKS`;
  - JB bit-index constants `OCC_BIT`=0 and `BUSY_BIT`=1, also used by the receiver side.
- One natural sub-module, `tick_counter`:
  - W-bit counter with synchronous clear;
  - increment on `tick`;
  - `hit` output when count equals the compare input.
- The FSM, operand latches and `JB` output register live in `sensor_emulator`.

## Test plan
- Reset, then idle for 100 cycles: `JB`=8'h00, `busy`=0, `done`=0 throughout.
- `arrive_delay`=3, `dwell`=5, bounce off, tick every 10 clk:
  - `JB[0]` rises after the 3rd tick +1 clk and stays high for exactly 5 ticks;
  - `done` pulses once for 1 cycle, then `busy`=0.
- Same operands with bounce on and `BOUNCE_TICKS`=4:
  - `JB[0]` sequence at arrival is 1,0,1,0 on successive ticks, then 1;
  - at departure it is 0,1,0,1, then 0;
  - exactly 8 toggles in total and a single `done`.
- `arrive_delay`=0, `dwell`=0, bounce off: `JB[0]` is high for exactly 1 clk, and `done` follows on the next clk.
- Abort, restart and rst during a run:
  - `abort` asserted in PARKED: next cycle `JB`=8'h00, `busy`=0, and no `done` ever.
  - A new `start` with `arrive_delay`=2 then runs normally.
  - `rst` asserted mid-BOUNCE_IN gives identical results.
- `start` pulsed again in WAIT_ARR with `arrive_delay`=1 while running with `arrive_delay`=6: ignored, arrival still occurs at tick 6.
